issue_unit: RTL
===============

Name: issue_unit

Overview:
- Single-issue scheduler between the dispatch-fed issue queues (ALU, LS/AGU, MUL, DIV) and the shared common data bus (CDB).
- Each cycle it grants at most one ready queue. It keeps a CDB slot-reservation shift register so no two functional units ever write back in the same cycle.
- It drives the per-cycle CDB owner select used by the CDB mux, and it tracks the non-pipelined divider's busy time.

Parameters:
- ALU_LAT, 1, issue-to-CDB latency of the ALU in cycles (≥1)
- LS_LAT, 1, issue-to-CDB latency of the AGU/LS unit (≥1)
- MUL_LAT, 4, issue-to-CDB latency of the pipelined multiplier (≥1)
- DIV_LAT, 7, issue-to-CDB latency of the non-pipelined divider; must be the largest latency

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- alu_ready  input  1  ALU queue holds an instruction with both operands valid
- ls_ready  input  1  LS queue holds a ready instruction
- mul_ready  input  1  MUL queue holds a ready instruction
- div_ready  input  1  DIV queue holds a ready instruction
- alu_issue  output  1  grant, ALU queue pops and starts this cycle
- ls_issue  output  1  grant to LS queue
- mul_issue  output  1  grant to MUL queue
- div_issue  output  1  grant to DIV queue
- div_busy  output  1  divider occupied, div_ready ignored
- cdb_valid  output  1  a unit drives the CDB this cycle
- cdb_owner  output  2  CDB mux select: 0 ALU, 1 LS, 2 MUL, 3 DIV; valid only when cdb_valid=1

Behaviour:
- Reservation state: `res[DIV_LAT:0]` plus `own[DIV_LAT:0][1:0]`.
  - `res[0]`/`own[0]` describe the current cycle's CDB.
  - `cdb_valid = res[0]`, `cdb_owner = own[0]`.
- Every cycle the state shifts down by one: `res[k] <= res[k+1]`, and `res[DIV_LAT]` fills with 0.
- Eligibility: a unit with latency L is eligible when ready=1 and `res[L]=0`, i.e. its CDB slot at t+L is free. DIV additionally requires div_busy=0.
- Grant priority (fixed, one grant maximum per cycle):
  - DIV first, then MUL, then ALU/LS.
  - ALU and LS share round-robin: a one-bit `last` flop records the last winner of that pair. When both are eligible, the other one wins. On reset, ALU has priority.
  - `last` updates only on an ALU or LS grant.
- Grant outputs are combinational from the ready inputs and current state, and are asserted in the same cycle.
- On a grant of latency L: `res[L-1] <= 1`, `own[L-1] <= code`. This write is applied on top of the shifted value. The result appears on the CDB exactly L cycles after the issue cycle.
- Divider tracking:
  - A 3-bit-minimum down-counter (width `$clog2(DIV_LAT+1)`) loads DIV_LAT-1 on div_issue.
  - `div_busy = (counter != 0)`, so the divider is busy the DIV_LAT-1 cycles after issue.
  - A new DIV can issue in the cycle its predecessor writes the CDB.
- Equal latencies (e.g. ALU_LAT=LS_LAT=1) are legal. The shared slot is resolved by single issue, so only one grant per cycle is possible.
- No ready inputs: no grant; the state keeps shifting.
- Reset (asynchronous, any time, including with a DIV in flight):
  - `res`, `own`, counter and `last` clear to 0.
  - All `*_issue`, cdb_valid and div_busy become 0 immediately.
  - cdb_owner becomes 0.
  - In-flight results are abandoned; the surrounding units are reset by the same rst.
- Elaboration check: DIV_LAT ≥ each other latency; otherwise `$error`.

Optional Feature:
- Macro: `ISSUE_PERF_CNT_EN`.
- When defined, the following are added:
  - 32-bit output counters `perf_alu_cnt`, `perf_ls_cnt`, `perf_mul_cnt`, `perf_div_cnt`, each counting its grants.
  - `perf_stall_cnt`, counting cycles where at least one ready input is 1 but no grant is issued.
  - All counters are reset to 0 by rst and wrap on overflow.
- When undefined, these ports and counters are absent and the core behaviour is identical.

Test Plan:
- Reset, then alu_ready=1 held for 3 cycles:
  - required: alu_issue=1 in cycles 0, 1, 2.
  - required: cdb_valid=1 with owner 0 in cycles 1, 2, 3.
- mul_ready pulsed at cycle 0, then alu_ready=1 from cycle 2:
  - required: mul_issue at 0; ALU granted at 2.
  - required: ALU blocked at cycle 3, since its slot equals the MUL slot at cycle 4.
  - required: owner 2 at cycle 4, ALU results at cycles 3 and 5.
- div_ready held high:
  - required: div_issue at 0 and 7, div_busy for cycles 1–6.
  - required: cdb_owner 3 at cycles 7 and 14.
- alu_ready and ls_ready both held high:
  - required: grants alternate ALU, LS, ALU, LS starting with ALU.
  - required: owners on the CDB alternate 0, 1, … one cycle later.
- All four ready at cycle 0:
  - required: div_issue only.
  - required: cycle 1 mul_issue.
  - required: cycle 2 ALU, cycle 3 LS.
  - required: no CDB collision through cycle 10.
- DIV issued, rst driven low at cycle 3 for 1 cycle:
  - required: div_busy and cdb_valid drop asynchronously.
  - required: no owner-3 CDB cycle at cycle 7.

Source files
------------

// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : issue_unit
//  Purpose  : Single-issue scheduler between the ALU, LS/AGU, MUL and DIV
//             issue queues and the shared common data bus (CDB). It grants at
//             most one ready queue per cycle. A CDB slot-reservation shift
//             register makes sure no two units write back in the same cycle.
//             The module also tracks the busy time of the non-pipelined
//             divider.
//  Ports    : clk, rst (asynchronous, active-low)
//             alu/ls/mul/div_ready  - queue holds a ready instruction
//             alu/ls/mul/div_issue  - same-cycle grant (combinational)
//             div_busy              - divider occupied, div_ready ignored
//             cdb_valid, cdb_owner  - CDB mux select (0 ALU,1 LS,2 MUL,3 DIV)
//  Option   : `define ISSUE_PERF_CNT_EN adds the perf_*_cnt grant/stall
//             counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_unit #(
    parameter int ALU_LAT = 1,
    parameter int LS_LAT  = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_ready,
    input  logic        ls_ready,
    input  logic        mul_ready,
    input  logic        div_ready,
    output logic        alu_issue,
    output logic        ls_issue,
    output logic        mul_issue,
    output logic        div_issue,
    output logic        div_busy,
    output logic        cdb_valid,
    output logic [1:0]  cdb_owner
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] perf_alu_cnt,
    output logic [31:0] perf_ls_cnt,
    output logic [31:0] perf_mul_cnt,
    output logic [31:0] perf_div_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CW = ($clog2(DIV_LAT + 1) < 3) ? 3 : $clog2(DIV_LAT + 1);

    localparam logic [1:0] OWN_ALU = 2'd0;
    localparam logic [1:0] OWN_LS  = 2'd1;
    localparam logic [1:0] OWN_MUL = 2'd2;
    localparam logic [1:0] OWN_DIV = 2'd3;

    if (ALU_LAT < 1 || LS_LAT < 1 || MUL_LAT < 1 ||
        DIV_LAT < ALU_LAT || DIV_LAT < LS_LAT || DIV_LAT < MUL_LAT) begin : g_lat_check
        $error("issue_unit: latencies must be >= 1 and DIV_LAT must be the largest");
    end

    // res[k]/own[k]: a result owned by own[k] lands on the CDB k cycles from now.
    logic [DIV_LAT:0]       res;
    logic [DIV_LAT:0][1:0]  own;
    logic [CW-1:0]          div_cnt;
    logic                   last_alu;   // 1: ALU won the ALU/LS pair last time

    logic alu_ok;
    logic ls_ok;
    logic mul_ok;
    logic div_ok;

    assign div_busy  = (div_cnt != '0);
    assign cdb_valid = res[0];
    assign cdb_owner = own[0];

    // Eligibility checks the slot the result would occupy (t + latency).
    assign alu_ok = alu_ready & ~res[ALU_LAT];
    assign ls_ok  = ls_ready  & ~res[LS_LAT];
    assign mul_ok = mul_ready & ~res[MUL_LAT];
    assign div_ok = div_ready & ~res[DIV_LAT] & ~div_busy;

    // Fixed priority DIV > MUL > {ALU,LS}. ALU and LS share a round robin.
    // Grants are gated by rst so they drop at once while reset is asserted.
    always_comb begin
        alu_issue = 1'b0;
        ls_issue  = 1'b0;
        mul_issue = 1'b0;
        div_issue = 1'b0;
        if (rst) begin
            if (div_ok) begin
                div_issue = 1'b1;
            end else if (mul_ok) begin
                mul_issue = 1'b1;
            end else if (alu_ok && ls_ok) begin
                if (last_alu) begin
                    ls_issue = 1'b1;
                end else begin
                    alu_issue = 1'b1;
                end
            end else if (alu_ok) begin
                alu_issue = 1'b1;
            end else if (ls_ok) begin
                ls_issue = 1'b1;
            end
        end
    end

    // Shift the reservation window. A grant then writes slot L-1 on top of
    // the shifted value, because that slot becomes slot 0 L-1 cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res      <= '0;
            own      <= '0;
            div_cnt  <= '0;
            last_alu <= 1'b0;
        end else begin
            res <= {1'b0, res[DIV_LAT:1]};
            own <= {2'b00, own[DIV_LAT:1]};
            if (div_issue) begin
                res[DIV_LAT-1] <= 1'b1;
                own[DIV_LAT-1] <= OWN_DIV;
            end
            if (mul_issue) begin
                res[MUL_LAT-1] <= 1'b1;
                own[MUL_LAT-1] <= OWN_MUL;
            end
            if (alu_issue) begin
                res[ALU_LAT-1] <= 1'b1;
                own[ALU_LAT-1] <= OWN_ALU;
                last_alu       <= 1'b1;
            end
            if (ls_issue) begin
                res[LS_LAT-1] <= 1'b1;
                own[LS_LAT-1] <= OWN_LS;
                last_alu      <= 1'b0;
            end
            if (div_issue) begin
                div_cnt <= CW'(DIV_LAT - 1);
            end else if (div_busy) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic any_ready;
    logic any_issue;
    assign any_ready = alu_ready | ls_ready | mul_ready | div_ready;
    assign any_issue = alu_issue | ls_issue | mul_issue | div_issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_alu_cnt   <= '0;
            perf_ls_cnt    <= '0;
            perf_mul_cnt   <= '0;
            perf_div_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (alu_issue) perf_alu_cnt <= perf_alu_cnt + 32'd1;
            if (ls_issue)  perf_ls_cnt  <= perf_ls_cnt  + 32'd1;
            if (mul_issue) perf_mul_cnt <= perf_mul_cnt + 32'd1;
            if (div_issue) perf_div_cnt <= perf_div_cnt + 32'd1;
            if (any_ready && !any_issue) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
